// File: rtl/vga_sync_if.sv
// Bundle between a VGA timing source and the sync decoder: raw sync/blank
// pins plus enable in one direction, recovered position and status back.
interface vga_sync_if #(
  parameter int unsigned CNT_W = 10
);
  logic             en;
  logic             vga_hsync;
  logic             vga_vsync;
  logic             hblank;
  logic             vblank;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             active;
  logic             line_start;
  logic             frame_start;
  logic [CNT_W-1:0] line_len;
  logic [CNT_W-1:0] frame_lines;
  logic             hsync_err;
  logic             vsync_err;
  logic             locked;

  modport master (
    output en, vga_hsync, vga_vsync, hblank, vblank,
    input  x, y, active, line_start, frame_start, line_len, frame_lines,
           hsync_err, vsync_err, locked
  );

  modport slave (
    input  en, vga_hsync, vga_vsync, hblank, vblank,
    output x, y, active, line_start, frame_start, line_len, frame_lines,
           hsync_err, vsync_err, locked
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// Recovers pixel/line position, line and frame lengths and a lock flag from
// sampled VGA sync/blank pins; all outputs are registered and mutually aligned.
module vga_sync_decoder #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter logic        HS_ACTIVE   = 1'b0,
  parameter logic        VS_ACTIVE   = 1'b0,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned CNT_W       = 10
) (
  input  logic      clk,
  input  logic      rst,
  vga_sync_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] X_TOUT    = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W:0]   ONE_W     = 1;
  localparam logic [CNT_W:0]   H_TOT_W   = H_TOTAL[CNT_W:0];
  localparam logic [CNT_W:0]   V_TOT_W   = V_TOTAL[CNT_W:0];
  localparam logic [3:0]       LOCK_LAST = 4'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {ST_UNLOCKED, ST_COUNTING, ST_LOCKED} lock_state_e;

  logic             hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q, hb_s1_q, vb_s1_q;
  logic             active_q, line_start_q, frame_start_q;
  logic             hsync_err_q, vsync_err_q, locked_q;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
  logic             h_valid_q, h_valid_d, v_valid_q, v_valid_d;
  logic             herr_seen_q, herr_seen_d;
  logic             hs_err_d, vs_err_d, frame_good;
  lock_state_e      state_q, state_d;
  logic [3:0]       good_cnt_q, good_cnt_d;

  logic             ls_det, fs_det;
  logic [CNT_W:0]   x_inc, y_inc;
  logic [CNT_W-1:0] x_sat, y_sat;

  assign ls_det = bus.en & (hs_s1_q == HS_ACTIVE) & (hs_s2_q != HS_ACTIVE);
  assign fs_det = bus.en & (vs_s1_q == VS_ACTIVE) & (vs_s2_q != VS_ACTIVE);

  // One extra bit keeps the length comparison exact once a counter has saturated.
  assign x_inc = {1'b0, x_q} + ONE_W;
  assign y_inc = {1'b0, y_q} + ONE_W;
  assign x_sat = x_inc[CNT_W] ? CNT_MAX : x_inc[CNT_W-1:0];
  assign y_sat = y_inc[CNT_W] ? CNT_MAX : y_inc[CNT_W-1:0];

  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    h_valid_d     = h_valid_q;
    v_valid_d     = v_valid_q;
    herr_seen_d   = herr_seen_q;
    hs_err_d      = 1'b0;
    vs_err_d      = 1'b0;
    frame_good    = 1'b0;
    state_d       = state_q;
    good_cnt_d    = good_cnt_q;

    if (bus.en) begin
      if (ls_det) begin
        x_d        = '0;
        line_len_d = x_sat;
        hs_err_d   = h_valid_q & (x_inc != H_TOT_W);
        h_valid_d  = 1'b1;
      end else begin
        x_d      = x_sat;
        hs_err_d = (x_q == X_TOUT);
      end

      if (fs_det) begin
        y_d           = '0;
        frame_lines_d = y_sat;
        vs_err_d      = v_valid_q & (y_inc != V_TOT_W);
        v_valid_d     = 1'b1;
      end else if (ls_det) begin
        y_d = y_sat;
      end

      // A line error landing on the closing frame_start belongs to that frame.
      frame_good = fs_det & ~vs_err_d & ~hs_err_d & ~herr_seen_q;
      if (fs_det)        herr_seen_d = 1'b0;
      else if (hs_err_d) herr_seen_d = 1'b1;

      if (hs_err_d | vs_err_d) begin
        state_d    = ST_UNLOCKED;
        good_cnt_d = '0;
      end else if (fs_det) begin
        case (state_q)
          ST_UNLOCKED: if (frame_good) begin
            state_d    = ST_COUNTING;
            good_cnt_d = '0;
          end
          ST_COUNTING: if (frame_good) begin
            good_cnt_d = good_cnt_q + 4'd1;
            if (good_cnt_q == LOCK_LAST) state_d = ST_LOCKED;
          end else begin
            state_d    = ST_UNLOCKED;
            good_cnt_d = '0;
          end
          ST_LOCKED: if (!frame_good) begin
            state_d    = ST_UNLOCKED;
            good_cnt_d = '0;
          end
          default: state_d = ST_UNLOCKED;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_s1_q       <= ~HS_ACTIVE;
      hs_s2_q       <= ~HS_ACTIVE;
      vs_s1_q       <= ~VS_ACTIVE;
      vs_s2_q       <= ~VS_ACTIVE;
      hb_s1_q       <= 1'b0;
      vb_s1_q       <= 1'b0;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hsync_err_q   <= 1'b0;
      vsync_err_q   <= 1'b0;
      locked_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      h_valid_q     <= 1'b0;
      v_valid_q     <= 1'b0;
      herr_seen_q   <= 1'b0;
      state_q       <= ST_UNLOCKED;
      good_cnt_q    <= '0;
    end else begin
      hs_s1_q       <= bus.vga_hsync;
      hs_s2_q       <= hs_s1_q;
      vs_s1_q       <= bus.vga_vsync;
      vs_s2_q       <= vs_s1_q;
      hb_s1_q       <= bus.hblank;
      vb_s1_q       <= bus.vblank;
      active_q      <= ~hb_s1_q & ~vb_s1_q;
      line_start_q  <= ls_det;
      frame_start_q <= fs_det;
      hsync_err_q   <= hs_err_d;
      vsync_err_q   <= vs_err_d;
      locked_q      <= (state_q == ST_LOCKED);
      x_q           <= x_d;
      y_q           <= y_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      h_valid_q     <= h_valid_d;
      v_valid_q     <= v_valid_d;
      herr_seen_q   <= herr_seen_d;
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
    end
  end

  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.active      = active_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;
  assign bus.line_len    = line_len_q;
  assign bus.frame_lines = frame_lines_q;
  assign bus.hsync_err   = hsync_err_q;
  assign bus.vsync_err   = vsync_err_q;
  assign bus.locked      = locked_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: scaled-down VGA timing with directed faults and
// random line/frame perturbations, compared cycle by cycle to an event model.
module tb_vga_sync_decoder;
  localparam int   H        = 40;
  localparam int   V        = 12;
  localparam int   LF       = 2;
  localparam int   CW       = 6;
  localparam int   MAXV     = 63;
  localparam int   HS_W     = 4;
  localparam int   H_ACT    = 32;
  localparam int   V_ACT    = 10;
  localparam int   VS_LINES = 2;
  localparam logic HS_ACT   = 1'b0;
  localparam logic VS_ACT   = 1'b0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_sync_if #(.CNT_W(CW)) bus ();

  vga_sync_decoder #(
    .H_TOTAL(H), .V_TOTAL(V), .HS_ACTIVE(HS_ACT), .VS_ACTIVE(VS_ACT),
    .LOCK_FRAMES(LF), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  // Reference model: positions are differences of enabled-clock timestamps,
  // lock is a streak of consecutive clean frame boundaries.
  int   m_ec, m_last, m_lines, m_streak, m_frames;
  bit   m_hv, m_vv, m_herr_seen, m_lk;
  logic m_hs1, m_hs2, m_vs1, m_vs2, m_hb1, m_vb1;
  int   e_x, e_y, e_llen, e_flines;
  bit   e_act, e_ls, e_fs, e_herr, e_verr, e_lock;

  task automatic model_edge(input logic r, input logic e, input logic hs,
                            input logic vs, input logic hb, input logic vb);
    int n;
    if (r) begin
      e_x = 0; e_y = 0; e_llen = 0; e_flines = 0;
      e_act = 0; e_ls = 0; e_fs = 0; e_herr = 0; e_verr = 0; e_lock = 0;
      m_ec = 0; m_last = 0; m_lines = 0; m_streak = 0;
      m_hv = 0; m_vv = 0; m_herr_seen = 0; m_lk = 0;
      m_hs1 = ~HS_ACT; m_hs2 = ~HS_ACT; m_vs1 = ~VS_ACT; m_vs2 = ~VS_ACT;
      m_hb1 = 1'b0; m_vb1 = 1'b0;
      return;
    end
    e_act  = !m_hb1 && !m_vb1;
    e_lock = m_lk;
    e_ls   = e && (m_hs1 == HS_ACT) && (m_hs2 != HS_ACT);
    e_fs   = e && (m_vs1 == VS_ACT) && (m_vs2 != VS_ACT);
    e_herr = 0;
    e_verr = 0;
    if (e) begin
      m_ec++;
      n = m_ec - m_last;
      if (e_ls) begin
        e_llen = sat(n);
        e_herr = m_hv && (n != H);
        m_hv   = 1;
        m_last = m_ec;
      end else if (n == MAXV) begin
        e_herr = 1;
      end
      e_x = sat(m_ec - m_last);
      if (e_fs) begin
        e_flines = sat(m_lines + 1);
        e_verr   = m_vv && ((m_lines + 1) != V);
        m_vv     = 1;
        m_lines  = 0;
      end else if (e_ls) begin
        m_lines++;
      end
      e_y = sat(m_lines);
      if (e_herr || e_verr) m_streak = 0;
      else if (e_fs)        m_streak = m_herr_seen ? 0 : m_streak + 1;
      if (e_fs)        m_herr_seen = 0;
      else if (e_herr) m_herr_seen = 1;
      m_lk = (m_streak >= LF + 1);
      if (e_fs) begin
        m_frames++;
        $display("frame %0d: lines=%0d vsync_err=%0d streak=%0d", m_frames, e_flines, e_verr, m_streak);
      end
    end
    m_hs2 = m_hs1; m_hs1 = hs;
    m_vs2 = m_vs1; m_vs1 = vs;
    m_hb1 = hb;    m_vb1 = vb;
  endtask

  int obs_herr, obs_verr, obs_fs, obs_coin, obs_xmax;

  task automatic step(input logic r, input logic e, input logic hs,
                      input logic vs, input logic hb, input logic vb);
    rst = r; bus.en = e; bus.vga_hsync = hs; bus.vga_vsync = vs;
    bus.hblank = hb; bus.vblank = vb;
    @(posedge clk);
    model_edge(r, e, hs, vs, hb, vb);
    @(negedge clk);
    check("x", int'(bus.x), e_x);
    check("y", int'(bus.y), e_y);
    check("active", int'(bus.active), int'(e_act));
    check("line_start", int'(bus.line_start), int'(e_ls));
    check("frame_start", int'(bus.frame_start), int'(e_fs));
    check("line_len", int'(bus.line_len), e_llen);
    check("frame_lines", int'(bus.frame_lines), e_flines);
    check("hsync_err", int'(bus.hsync_err), int'(e_herr));
    check("vsync_err", int'(bus.vsync_err), int'(e_verr));
    check("locked", int'(bus.locked), int'(e_lock));
    if (bus.hsync_err) obs_herr++;
    if (bus.vsync_err) obs_verr++;
    if (bus.frame_start) obs_fs++;
    if (bus.frame_start && bus.line_start) obs_coin++;
    if (int'(bus.x) > obs_xmax) obs_xmax = int'(bus.x);
  endtask

  // win_kind: 0 none, 1 enable low, 2 reset, over [win_at, win_at+win_len).
  task automatic drive_line(input int len, input int row, input bit stuck,
                            input int win_at, input int win_len, input int win_kind);
    for (int c = 0; c < len; c++) begin
      logic hs, vs, hb, vb, r, e;
      bit   inwin;
      inwin = (c >= win_at) && (c < win_at + win_len);
      hs = (!stuck && c < HS_W) ? HS_ACT : ~HS_ACT;
      vs = (row < VS_LINES) ? VS_ACT : ~VS_ACT;
      hb = (c >= H_ACT);
      vb = (row >= V_ACT);
      r  = inwin && (win_kind == 2);
      e  = !(inwin && (win_kind == 1));
      step(r, e, hs, vs, hb, vb);
    end
  endtask

  task automatic drive_rows(input int from, input int to);
    for (int row = from; row <= to; row++) drive_line(H, row, 1'b0, -1, 0, 0);
  endtask

  task automatic drive_frame(input int nl, input int odd_row, input int odd_len);
    for (int row = 0; row < nl; row++)
      drive_line((row == odd_row) ? odd_len : H, row, 1'b0, -1, 0, 0);
  endtask

  task automatic random_frames(input int nframes);
    int nl, len, wa, wl, wk;
    for (int f = 0; f < nframes; f++) begin
      nl = V;
      if ($urandom_range(0, 3) == 0) nl = V - 1 + int'($urandom_range(0, 2));
      for (int row = 0; row < nl; row++) begin
        len = H; wa = -1; wl = 0; wk = 0;
        case ($urandom_range(0, 15))
          0: len = H - 2 + int'($urandom_range(0, 4));
          1: begin wa = int'($urandom_range(4, 30)); wl = int'($urandom_range(1, 8)); wk = 1; end
          default: ;
        endcase
        drive_line(len, row, 1'b0, wa, wl, wk);
      end
    end
  endtask

  task automatic clear_obs();
    obs_herr = 0; obs_verr = 0; obs_fs = 0; obs_coin = 0; obs_xmax = 0;
  endtask

  initial begin
    m_frames = 0;
    clear_obs();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, ~HS_ACT, ~VS_ACT, 1'b1, 1'b1);
    check("rst_x", int'(bus.x), 0);
    check("rst_y", int'(bus.y), 0);
    check("rst_line_len", int'(bus.line_len), 0);
    check("rst_locked", int'(bus.locked), 0);

    // Nominal timing; vsync and hsync fall on the same clock every frame.
    clear_obs();
    for (int f = 0; f < 4; f++) drive_frame(V, -1, H);
    check("nom_locked", int'(bus.locked), 1);
    check("nom_line_len", int'(bus.line_len), H);
    check("nom_frame_lines", int'(bus.frame_lines), V);
    check("nom_err_cnt", obs_herr + obs_verr, 0);
    check("nom_fs_cnt", obs_fs, 4);
    check("nom_coincident_cnt", obs_coin, 4);

    // One short line: a single error, relock after three clean boundaries.
    clear_obs();
    drive_frame(V, 5, H - 1);
    check("short_herr_cnt", obs_herr, 1);
    check("short_locked", int'(bus.locked), 0);
    for (int f = 0; f < 4; f++) drive_frame(V, -1, H);
    check("relock_locked", int'(bus.locked), 1);

    // hsync stuck inactive for a long line: x saturates, one timeout error.
    drive_rows(0, 2);
    clear_obs();
    drive_line(70, 3, 1'b1, -1, 0, 0);
    check("stuck_herr_cnt", obs_herr, 1);
    check("stuck_xmax", obs_xmax, MAXV);
    check("stuck_locked", int'(bus.locked), 0);
    drive_rows(4, V - 1);
    drive_frame(V, -1, H);

    // Enable dropped mid-line: counters freeze, measured line comes up short.
    clear_obs();
    drive_rows(0, 3);
    drive_line(H, 4, 1'b0, 10, 15, 1);
    drive_rows(5, V - 1);
    check("gap_herr_cnt", obs_herr, 1);

    // Reset mid-frame: the first edges afterwards only re-arm measurement.
    drive_rows(0, 5);
    drive_line(H, 6, 1'b0, 12, 3, 2);
    clear_obs();
    drive_rows(7, V - 1);
    drive_frame(V, -1, H);
    drive_frame(V, -1, H);
    check("post_rst_err_cnt", obs_herr + obs_verr, 0);

    random_frames(8);
    drive_frame(V, -1, H);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
